// File: rtl/tx_eq_pkg.sv
// Shared TX-equalization types: coefficient word, handshake FSM encoding, legality helper.
// Pure declarations; no timing or flow control of its own.
package tx_eq_pkg;

  localparam int EQ_W     = 6;
  localparam int EQ_FOM_W = 8;

  typedef logic [EQ_W-1:0] coeff_t;

  typedef enum logic [2:0] {
    EQ_IDLE     = 3'd0,
    EQ_CHECK    = 3'd1,
    EQ_REQ      = 3'd2,
    EQ_WAIT_ACK = 3'd3,
    EQ_SETTLE   = 3'd4,
    EQ_WAIT_FOM = 3'd5,
    EQ_NEXT     = 3'd6,
    EQ_DONE     = 3'd7
  } eq_state_t;

  // Two guard bits keep cm+cp and C0-cm-cp from wrapping at the sweep limits.
  function automatic logic is_legal(coeff_t fs, coeff_t lf, coeff_t cm, coeff_t cp);
    logic signed [EQ_W+1:0] s_fs;
    logic signed [EQ_W+1:0] s_sum;
    logic signed [EQ_W+1:0] s_c0;
    s_fs  = $signed({2'b00, fs});
    s_sum = $signed({2'b00, cm}) + $signed({2'b00, cp});
    s_c0  = s_fs - s_sum;
    return (s_sum <= s_fs) &&
           ($signed({2'b00, cm}) <= (s_fs >>> 2)) &&
           ((s_c0 - s_sum) >= $signed({2'b00, lf}));
  endfunction

endpackage

// File: rtl/rx_eq_coeff_requester_if.sv
// Coefficient request handshake between the RX requester and the partner tx_driver port.
// req_valid holds the coefficients stable until a one-cycle tx_ack or tx_reject pulse.
interface rx_eq_coeff_requester_if #(
  parameter int W = 6
);
  logic         req_valid;
  logic [W-1:0] req_C1_minus;
  logic [W-1:0] req_C0;
  logic [W-1:0] req_C1_plus;
  logic         tx_ack;
  logic         tx_reject;

  modport master (
    output req_valid, req_C1_minus, req_C0, req_C1_plus,
    input  tx_ack, tx_reject
  );

  modport slave (
    input  req_valid, req_C1_minus, req_C0, req_C1_plus,
    output tx_ack, tx_reject
  );
endinterface

// File: rtl/eq_coeff_check.sv
// Main-cursor derivation and legality of a (C-1, C+1) pair against partner FS/LF.
// Purely combinational, zero latency; no flow control.
module eq_coeff_check #(
  parameter int W = 6
) (
  input  logic [W-1:0] fs,
  input  logic [W-1:0] lf,
  input  logic [W-1:0] cm,
  input  logic [W-1:0] cp,
  output logic [W-1:0] c0,
  output logic         legal
);
  logic signed [W+1:0] s_fs;
  logic signed [W+1:0] s_lf;
  logic signed [W+1:0] s_cm;
  logic signed [W+1:0] s_cp;
  logic signed [W+1:0] s_sum;
  logic signed [W+1:0] s_c0;

  assign s_fs  = $signed({2'b00, fs});
  assign s_lf  = $signed({2'b00, lf});
  assign s_cm  = $signed({2'b00, cm});
  assign s_cp  = $signed({2'b00, cp});
  assign s_sum = s_cm + s_cp;
  assign s_c0  = s_fs - s_sum;

  // c0 is only meaningful when legal, where it is guaranteed non-negative.
  assign c0    = s_c0[W-1:0];
  assign legal = (s_sum <= s_fs) && (s_cm <= (s_fs >>> 2)) && ((s_c0 - s_sum) >= s_lf);
endmodule

// File: rtl/rx_eq_coeff_requester.sv
// Sweeps legal (C-1,C0,C+1) points, requests each from the partner and keeps the best-FOM point.
// Legal point: 2 + ack delay + SETTLE_CYCLES + FOM delay + 1 cycles, illegal 2; waits bounded by TIMEOUT.
module rx_eq_coeff_requester
  import tx_eq_pkg::*;
#(
  parameter int W             = EQ_W,
  parameter int FOM_W         = EQ_FOM_W,
  parameter int STEP          = 1,
  parameter int CM_MAX        = 16,
  parameter int CP_MAX        = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int TIMEOUT       = 64
) (
  input  logic                    bit_clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [W-1:0]            FS,
  input  logic [W-1:0]            LF,
  input  logic                    fom_valid,
  input  logic [FOM_W-1:0]        fom,
  rx_eq_coeff_requester_if.master rq,
  output logic                    busy,
  output logic                    done,
  output logic                    best_valid,
  output logic [W-1:0]            best_C1_minus,
  output logic [W-1:0]            best_C0,
  output logic [W-1:0]            best_C1_plus,
  output logic [FOM_W-1:0]        best_fom,
  output logic                    timeout_err
);
  localparam logic [2:0] ST_IDLE     = EQ_IDLE;
  localparam logic [2:0] ST_CHECK    = EQ_CHECK;
  localparam logic [2:0] ST_REQ      = EQ_REQ;
  localparam logic [2:0] ST_WAIT_ACK = EQ_WAIT_ACK;
  localparam logic [2:0] ST_SETTLE   = EQ_SETTLE;
  localparam logic [2:0] ST_WAIT_FOM = EQ_WAIT_FOM;
  localparam logic [2:0] ST_NEXT     = EQ_NEXT;
  localparam logic [2:0] ST_DONE     = EQ_DONE;

  localparam int CW = $clog2((TIMEOUT > SETTLE_CYCLES) ? TIMEOUT : SETTLE_CYCLES) + 1;

  logic [2:0]    state;
  logic [W-1:0]  fs_q;
  logic [W-1:0]  lf_q;
  logic [W-1:0]  cm;
  logic [W-1:0]  cp;
  logic [W-1:0]  c0;
  logic          legal;
  logic [CW-1:0] cnt;
  logic [W+1:0]  cm_inc;
  logic [W+1:0]  cp_inc;

  eq_coeff_check #(.W(W)) u_check (
    .fs    (fs_q),
    .lf    (lf_q),
    .cm    (cm),
    .cp    (cp),
    .c0    (c0),
    .legal (legal)
  );

  assign cm_inc = {2'b00, cm} + (W+2)'(STEP);
  assign cp_inc = {2'b00, cp} + (W+2)'(STEP);

  assign rq.req_valid = (state == ST_REQ) || (state == ST_WAIT_ACK);
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);

  always_ff @(posedge bit_clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      fs_q            <= '0;
      lf_q            <= '0;
      cm              <= '0;
      cp              <= '0;
      cnt             <= '0;
      rq.req_C1_minus <= '0;
      rq.req_C0       <= '0;
      rq.req_C1_plus  <= '0;
      best_valid      <= 1'b0;
      best_C1_minus   <= '0;
      best_C0         <= '0;
      best_C1_plus    <= '0;
      best_fom        <= '0;
      timeout_err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            fs_q          <= FS;
            lf_q          <= LF;
            cm            <= '0;
            cp            <= '0;
            best_valid    <= 1'b0;
            best_C1_minus <= '0;
            best_C0       <= '0;
            best_C1_plus  <= '0;
            best_fom      <= '0;
            timeout_err   <= 1'b0;
            state         <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (legal) begin
            rq.req_C1_minus <= cm;
            rq.req_C0       <= c0;
            rq.req_C1_plus  <= cp;
            state           <= ST_REQ;
          end else begin
            state <= ST_NEXT;
          end
        end
        ST_REQ: begin
          cnt   <= '0;
          state <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          // Reject takes priority when both strobes coincide.
          if (rq.tx_reject) begin
            state <= ST_NEXT;
          end else if (rq.tx_ack) begin
            cnt   <= '0;
            state <= ST_SETTLE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= ST_NEXT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_SETTLE: begin
          if (cnt == CW'(SETTLE_CYCLES - 1)) begin
            cnt   <= '0;
            state <= ST_WAIT_FOM;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_WAIT_FOM: begin
          if (fom_valid) begin
            if (!best_valid || (fom > best_fom)) begin
              best_C1_minus <= rq.req_C1_minus;
              best_C0       <= rq.req_C0;
              best_C1_plus  <= rq.req_C1_plus;
              best_fom      <= fom;
            end
            best_valid <= 1'b1;
            state      <= ST_NEXT;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= ST_NEXT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_NEXT: begin
          if (cp_inc > (W+2)'(CP_MAX)) begin
            cp <= '0;
            if (cm_inc > (W+2)'(CM_MAX)) begin
              state <= ST_DONE;
            end else begin
              cm    <= cm_inc[W-1:0];
              state <= ST_CHECK;
            end
          end else begin
            cp    <= cp_inc[W-1:0];
            state <= ST_CHECK;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rx_eq_coeff_requester.sv
// Directed sweeps against a scripted link partner; expected results are hand-computed per vector.
module tb_rx_eq_coeff_requester;
  localparam int ACK_DLY = 3;

  logic       bit_clk = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] FS;
  logic [5:0] LF;
  logic       fom_valid;
  logic [7:0] fom;
  logic       busy;
  logic       done;
  logic       best_valid;
  logic [5:0] best_C1_minus;
  logic [5:0] best_C0;
  logic [5:0] best_C1_plus;
  logic [7:0] best_fom;
  logic       timeout_err;

  rx_eq_coeff_requester_if #(.W(6)) rq ();

  rx_eq_coeff_requester dut (
    .bit_clk       (bit_clk),
    .reset         (reset),
    .start         (start),
    .FS            (FS),
    .LF            (LF),
    .fom_valid     (fom_valid),
    .fom           (fom),
    .rq            (rq),
    .busy          (busy),
    .done          (done),
    .best_valid    (best_valid),
    .best_C1_minus (best_C1_minus),
    .best_C0       (best_C0),
    .best_C1_plus  (best_C1_plus),
    .best_fom      (best_fom),
    .timeout_err   (timeout_err)
  );

  always #5 bit_clk = ~bit_clk;

  // Partner modes: 0 ack, 1 reject odd cp, 2 never ack, 3 ack without FOM, 4 ack+reject, 5 FOM during settle
  typedef struct {
    int fs; int lf; int mode; bit mid_start;
    int reqs; int run; int busy_c;
    bit bv; bit to;
    int bcm; int bc0; int bcp; int bfom;
    int pcm; int pc0; int pcp; bit pseen;
  } vec_t;

  vec_t vt[8];

  int n_vec = 0;
  int n_bad = 0;
  int epoch = 0;
  int mode = 0;
  int cur_fs = 0;
  int cur_lf = 0;
  int probe_cm = 0;
  int probe_c0 = 0;
  int probe_cp = 0;

  int mon_epoch = 0;
  int req_cnt, bad_req, run_cur, run_max, busy_cyc, done_cnt, done_run, done_max;
  bit probe_hit;
  bit prev_v, prev_d;
  logic [5:0] pm, p0, pp;

  int resp_age, resp_fcnt, acm, acp;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit legal_pt(int fs, int lf, int cm, int cp);
    return (cm + cp <= fs) && (cm <= fs / 4) && (fs - 2 * (cm + cp) >= lf);
  endfunction

  function automatic logic [7:0] fom_of(int md, int cm, int cp);
    if (md == 1) return (cp % 2 == 1) ? 8'd200 : 8'(cp * 10 + cm);
    return (cm == 10 && cp == 10) ? 8'd100 : 8'd20;
  endfunction

  // Scripted link partner: answers each request ACK_DLY cycles after req_valid rises.
  initial begin : responder
    rq.tx_ack = 1'b0; rq.tx_reject = 1'b0; fom_valid = 1'b0; fom = '0;
    resp_age = 0; resp_fcnt = 0; acm = 0; acp = 0;
    forever begin
      @(negedge bit_clk);
      rq.tx_ack = 1'b0; rq.tx_reject = 1'b0; fom_valid = 1'b0; fom = '0;
      if (reset) begin
        resp_age = 0; resp_fcnt = 0;
      end else begin
        if (resp_fcnt != 0) begin
          resp_fcnt++;
          if (mode == 5 && resp_fcnt == 4) begin fom_valid = 1'b1; fom = 8'd255; end
          if (resp_fcnt == 11) begin
            if (mode != 3) begin fom_valid = 1'b1; fom = fom_of(mode == 1 ? 1 : 0, acm, acp); end
            resp_fcnt = 0;
          end
        end
        if (rq.req_valid) begin
          resp_age++;
          if (resp_age == ACK_DLY) begin
            if (mode == 4) begin
              rq.tx_ack = 1'b1; rq.tx_reject = 1'b1;
            end else if (mode == 1 && rq.req_C1_plus[0]) begin
              rq.tx_reject = 1'b1;
            end else if (mode != 2) begin
              rq.tx_ack = 1'b1; resp_fcnt = 1;
              acm = int'(rq.req_C1_minus); acp = int'(rq.req_C1_plus);
            end
          end
        end else begin
          resp_age = 0;
        end
      end
    end
  end

  // Observes requests, busy/done timing; counters restart whenever epoch changes.
  initial begin : monitor
    prev_v = 1'b0; prev_d = 1'b0; pm = '0; p0 = '0; pp = '0;
    forever begin
      @(negedge bit_clk);
      if (epoch != mon_epoch) begin
        mon_epoch = epoch;
        req_cnt = 0; bad_req = 0; run_cur = 0; run_max = 0; busy_cyc = 0;
        done_cnt = 0; done_run = 0; done_max = 0; probe_hit = 1'b0;
      end
      if (rq.req_valid) begin
        if (!prev_v) begin
          int m, c, p;
          m = int'(rq.req_C1_minus); c = int'(rq.req_C0); p = int'(rq.req_C1_plus);
          req_cnt++;
          if (!legal_pt(cur_fs, cur_lf, m, p) || c != cur_fs - m - p) bad_req++;
          if (m == probe_cm && c == probe_c0 && p == probe_cp) probe_hit = 1'b1;
        end else if ({rq.req_C1_minus, rq.req_C0, rq.req_C1_plus} != {pm, p0, pp}) begin
          bad_req++;
        end
        run_cur++;
        if (run_cur > run_max) run_max = run_cur;
      end else begin
        run_cur = 0;
      end
      if (busy) busy_cyc++;
      if (done) begin
        if (!prev_d) done_cnt++;
        done_run++;
        if (done_run > done_max) done_max = done_run;
      end else begin
        done_run = 0;
      end
      prev_v = rq.req_valid; prev_d = done;
      pm = rq.req_C1_minus; p0 = rq.req_C0; pp = rq.req_C1_plus;
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    epoch++;
    cur_fs = v.fs; cur_lf = v.lf; mode = v.mode;
    probe_cm = v.pcm; probe_c0 = v.pc0; probe_cp = v.pcp;
    @(negedge bit_clk);
    FS = 6'(v.fs); LF = 6'(v.lf); start = 1'b1;
    @(negedge bit_clk);
    start = 1'b0;
    for (int c = 0; c < 20000 && done_cnt == 0; c++) begin
      @(negedge bit_clk);
      if (v.mid_start && c == 100) begin
        start = 1'b1; FS = 6'd8; LF = 6'd0;
      end else if (v.mid_start && c == 101) begin
        start = 1'b0; FS = 6'(v.fs); LF = 6'(v.lf);
      end
    end
    repeat (3) @(negedge bit_clk);
    check($sformatf("v%0d_done_pulses", idx), done_cnt, 1);
    check($sformatf("v%0d_done_width", idx), done_max, 1);
    check($sformatf("v%0d_requests", idx), req_cnt, v.reqs);
    check($sformatf("v%0d_bad_requests", idx), bad_req, 0);
    check($sformatf("v%0d_probe_seen", idx), int'(probe_hit), int'(v.pseen));
    check($sformatf("v%0d_req_valid_run", idx), run_max, v.run);
    check($sformatf("v%0d_busy_cycles", idx), busy_cyc, v.busy_c);
    check($sformatf("v%0d_busy_after", idx), int'(busy), 0);
    check($sformatf("v%0d_best_valid", idx), int'(best_valid), int'(v.bv));
    check($sformatf("v%0d_timeout_err", idx), int'(timeout_err), int'(v.to));
    check($sformatf("v%0d_best_cm", idx), int'(best_C1_minus), v.bcm);
    check($sformatf("v%0d_best_c0", idx), int'(best_C0), v.bc0);
    check($sformatf("v%0d_best_cp", idx), int'(best_C1_plus), v.bcp);
    check($sformatf("v%0d_best_fom", idx), int'(best_fom), v.bfom);
  endtask

  initial begin : main
    //        fs lf md mid reqs run busy  bv to  best cm/c0/cp/fom  probe cm/c0/cp seen
    vt[0] = '{63, 0, 0, 1'b0, 272,  3, 4115, 1'b1, 1'b0, 10, 43, 10, 100, 10, 43, 10, 1'b1};
    vt[1] = '{24, 8, 0, 1'b1,  42,  3, 1125, 1'b1, 1'b0,  0, 24,  0,  20,  0, 24,  0, 1'b1};
    vt[2] = '{24, 8, 1, 1'b0,  42,  3,  935, 1'b1, 1'b0,  0, 16,  8,  80,  7, 17,  0, 1'b0};
    vt[3] = '{ 8, 0, 2, 1'b0,  12, 65, 1359, 1'b0, 1'b1,  0,  0,  0,   0,  2,  4,  2, 1'b1};
    vt[4] = '{ 8, 0, 3, 1'b0,  12,  3, 1479, 1'b0, 1'b1,  0,  0,  0,   0,  0,  8,  0, 1'b1};
    vt[5] = '{ 0, 1, 0, 1'b0,   0,  0,  579, 1'b0, 1'b0,  0,  0,  0,   0,  0,  0,  0, 1'b0};
    vt[6] = '{63, 0, 4, 1'b0, 272,  3, 1395, 1'b0, 1'b0,  0,  0,  0,   0, 15, 32, 16, 1'b1};
    vt[7] = '{ 8, 0, 5, 1'b0,  12,  3,  735, 1'b1, 1'b0,  0,  8,  0,  20,  3,  5,  0, 1'b0};

    reset = 1'b1; start = 1'b0; FS = '0; LF = '0;
    repeat (3) @(negedge bit_clk);
    check("rst_ctrl", int'({rq.req_valid, busy, done, best_valid, timeout_err}), 0);
    check("rst_best_coeffs", int'({best_C1_minus, best_C0, best_C1_plus}), 0);
    check("rst_best_fom", int'(best_fom), 0);
    check("rst_req_coeffs", int'({rq.req_C1_minus, rq.req_C0, rq.req_C1_plus}), 0);
    reset = 1'b0;

    // Reset in the middle of a sweep, while waiting for the second point's FOM.
    mode = 0; cur_fs = 63; cur_lf = 0;
    @(negedge bit_clk);
    FS = 6'd63; LF = 6'd0; start = 1'b1;
    @(negedge bit_clk);
    start = 1'b0;
    begin
      int w;
      w = 0;
      while (!best_valid && w < 200) begin
        @(negedge bit_clk);
        w++;
      end
    end
    check("midrst_first_score", int'(best_valid), 1);
    repeat (13) @(negedge bit_clk);
    check("midrst_busy_before", int'(busy), 1);
    reset = 1'b1;
    @(negedge bit_clk);
    check("midrst_req_valid", int'(rq.req_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_best_valid", int'(best_valid), 0);
    check("midrst_best_fom", int'(best_fom), 0);
    @(negedge bit_clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vt[i], i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
